// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encodings, opcode/ext and
// condition codes, immediate width, and the instruction-class decoder.
package pc_seq_pkg;

  localparam int IMMWIDTH = 8;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;

  localparam logic [3:0] OP_BCOND  = 4'hC;
  localparam logic [3:0] OP_EXT    = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;

  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  // Bit positions inside the {C,L,F,Z,N} flag vector.
  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_BCOND = 3'd1,
    CLS_JCOND = 3'd2,
    CLS_JAL   = 3'd3,
    CLS_LOAD  = 3'd4,
    CLS_STOR  = 3'd5
  } instr_class_t;

  function automatic instr_class_t decode_class(input logic [3:0] opcode,
                                                input logic [3:0] ext);
    instr_class_t cls;
    cls = CLS_ALU;
    if (opcode == OP_BCOND) begin
      cls = CLS_BCOND;
    end else if (opcode == OP_EXT) begin
      case (ext)
        EXT_JCOND: cls = CLS_JCOND;
        EXT_JAL:   cls = CLS_JAL;
        EXT_LOAD:  cls = CLS_LOAD;
        EXT_STOR:  cls = CLS_STOR;
        default:   cls = CLS_ALU;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Handshake bundle between the PC sequencer and its surroundings
// (instruction fetch, PSR flags, data memory, PC block).
interface pc_seq_if;
  import pc_seq_pkg::*;

  logic [15:0]         instr;
  logic                instr_valid;
  logic [4:0]          flags;
  logic                mem_ready;
  logic                halt;
  logic                pcEn;
  logic                branch;
  logic                jump;
  logic [IMMWIDTH-1:0] disp;
  logic [15:0]         ir;
  logic                fetch_req;
  logic                mem_req;
  logic                mem_we;
  logic                link_we;
  logic [2:0]          state;

  modport master (
    input  instr, instr_valid, flags, mem_ready, halt,
    output pcEn, branch, jump, disp, ir, fetch_req, mem_req, mem_we,
           link_we, state
  );

  modport slave (
    output instr, instr_valid, flags, mem_ready, halt,
    input  pcEn, branch, jump, disp, ir, fetch_req, mem_req, mem_we,
           link_we, state
  );

endinterface

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: cond code against the {C,L,F,Z,N} flags.
module cond_eval
  import pc_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       take
);

  logic c, l, f, z, n;

  assign c = flags[FLAG_C];
  assign l = flags[FLAG_L];
  assign f = flags[FLAG_F];
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];

  always_comb begin
    take = 1'b0;
    case (cond)
      CC_EQ: take = z;
      CC_NE: take = !z;
      CC_CS: take = c;
      CC_CC: take = !c;
      CC_HI: take = l;
      CC_LS: take = !l;
      CC_GT: take = n;
      CC_LE: take = !n;
      CC_FS: take = f;
      CC_FC: take = !f;
      CC_LO: take = !l && !z;
      CC_HS: take = l || z;
      CC_LT: take = !n && !z;
      CC_GE: take = n || z;
      CC_UC: take = 1'b1;
      CC_NV: take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// Multi-cycle PC sequencer: FETCH -> DECODE -> EXEC [-> MEM] per instruction,
// driving the PC block's pcEn/branch/jump/disp strobes.
module pc_seq
  import pc_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  pc_seq_if.master bus
);

  logic [2:0]   state_r;
  logic [2:0]   state_nxt;
  logic [15:0]  ir_r;
  instr_class_t cls;
  logic         take;
  logic         pc_en;
  logic         br;
  logic         jmp;
  logic         lnk;
  logic         f_req;
  logic         m_req;
  logic         m_we;
  logic         load_ir;

  assign cls = decode_class(ir_r[15:12], ir_r[7:4]);

  // One evaluator serves both the Bcond and Jcond paths.
  cond_eval u_cond (
    .cond  (ir_r[11:8]),
    .flags (bus.flags),
    .take  (take)
  );

  assign load_ir = (state_r == ST_FETCH) && !bus.halt && bus.instr_valid;

  always_comb begin
    state_nxt = ST_FETCH;
    case (state_r)
      ST_FETCH:  state_nxt = load_ir ? ST_DECODE : ST_FETCH;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = (cls == CLS_LOAD || cls == CLS_STOR) ? ST_MEM : ST_FETCH;
      ST_MEM:    state_nxt = bus.mem_ready ? ST_FETCH : ST_MEM;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_en = 1'b0;
    br    = 1'b0;
    jmp   = 1'b0;
    lnk   = 1'b0;
    f_req = 1'b0;
    m_req = 1'b0;
    m_we  = 1'b0;
    case (state_r)
      ST_FETCH: f_req = !bus.halt;
      ST_EXEC: begin
        case (cls)
          CLS_ALU:   pc_en = 1'b1;
          CLS_BCOND: begin
            pc_en = 1'b1;
            br    = take;
          end
          CLS_JCOND: begin
            pc_en = 1'b1;
            jmp   = take;
          end
          CLS_JAL: begin
            pc_en = 1'b1;
            jmp   = 1'b1;
            lnk   = 1'b1;
          end
          default: pc_en = 1'b0;
        endcase
      end
      ST_MEM: begin
        m_req = 1'b1;
        m_we  = (cls == CLS_STOR);
        pc_en = bus.mem_ready;
      end
      default: pc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_FETCH;
      ir_r    <= '0;
    end else begin
      state_r <= state_nxt;
      if (load_ir) ir_r <= bus.instr;
    end
  end

  // Outputs are forced low for as long as reset is held, not just after an edge.
  assign bus.pcEn      = rst && pc_en;
  assign bus.branch    = rst && br;
  assign bus.jump      = rst && jmp;
  assign bus.link_we   = rst && lnk;
  assign bus.fetch_req = rst && f_req;
  assign bus.mem_req   = rst && m_req;
  assign bus.mem_we    = rst && m_we;
  assign bus.disp      = rst ? ir_r[IMMWIDTH-1:0] : '0;
  assign bus.ir        = rst ? ir_r : '0;
  assign bus.state     = rst ? state_r : '0;

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-003 The block SHALL have port instr, input, 16 bits: instruction word from instruction memory.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-005 The block SHALL have port flags, input, 5 bits: {C,L,F,Z,N}, taken from the PSR.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: the data-memory access completes this cycle.
REQ-007 The block SHALL have port halt, input, 1 bit: suspends fetching.
REQ-008 The block SHALL have outputs pcEn, branch and jump, each 1 bit: the PC control strobes.
REQ-009 The block SHALL have output disp, 8 bits: branch displacement, equal to ir[7:0].
REQ-010 The block SHALL have output ir, 16 bits: the registered instruction.
REQ-011 The block SHALL have outputs fetch_req, mem_req, mem_we and link_we, each 1 bit.
REQ-012 The block SHALL have output state, 3 bits: current FSM state, for debug.

Function
REQ-013 The FSM SHALL have four states: FETCH=0, DECODE=1, EXEC=2, MEM=3.
REQ-014 FETCH behaviour:
- halt=0: fetch_req=1.
- instr_valid=1 while halt=0: ir<=instr at the clock edge, and the next state is DECODE.
- halt=1: fetch_req=0, instr_valid is ignored, and the FSM stays in FETCH.
REQ-015 DECODE SHALL assert no outputs and SHALL always go to EXEC on the next cycle.
REQ-016 Instruction decode:
- opcode = ir[15:12]; ext = ir[7:4].
- Bcond: opcode 4'hC.
- Jcond: opcode 4'h4, ext 4'hC.
- JAL: opcode 4'h4, ext 4'h8.
- LOAD: opcode 4'h4, ext 4'h0.
- STOR: opcode 4'h4, ext 4'h4.
- Every other encoding is ALU class.
REQ-017 The condition code SHALL be cond = ir[11:8] and SHALL evaluate as follows:
- EQ Z; NE !Z; CS C; CC !C; HI L; LS !L; GT N; LE !N.
- FS F; FC !F; LO !L&!Z; HS L|Z; LT !N&!Z; GE N|Z.
- 4'hE: always true; 4'hF: never true.
REQ-018 In EXEC, ALU class SHALL assert pcEn=1 only and SHALL go to FETCH.
REQ-019 In EXEC, Bcond SHALL assert pcEn=1 and branch=(cond true), and SHALL go to FETCH.
REQ-020 In EXEC, Jcond SHALL assert pcEn=1 and jump=(cond true), and SHALL go to FETCH.
REQ-021 In EXEC, JAL SHALL assert pcEn=1, jump=1 and link_we=1, and SHALL go to FETCH.
REQ-022 In EXEC, LOAD and STOR SHALL assert no strobes and SHALL go to MEM.
REQ-023 MEM behaviour:
- mem_req=1 throughout; mem_we=1 for STOR, 0 for LOAD.
- Stay in MEM while mem_ready=0.
- mem_ready=1: pcEn=1 in that same cycle, then go to FETCH.
REQ-024 branch and jump SHALL never both be 1 in the same cycle, and each SHALL be 1 only when pcEn=1.
REQ-025 pcEn SHALL be a single-cycle pulse, asserted exactly once per instruction.
REQ-026 All strobes SHALL be combinational from the registered state, ir, flags and mem_ready.
REQ-027 The FSM SHALL contain no combinational path from instr to any output.
REQ-028 Latency SHALL be 3 cycles from the instr_valid edge to the pcEn cycle for non-memory instructions.
REQ-029 For LOAD/STOR, latency SHALL be at least 4 cycles, plus one cycle per cycle that mem_ready is low.
REQ-030 An undefined state encoding SHALL go to FETCH on the next edge, with all strobes 0.

Reset
REQ-031 While rst=0, every output SHALL be 0, including state and ir.
REQ-032 At a clock edge with rst=0, the FSM SHALL load FETCH and ir SHALL load 16'h0000.
REQ-033 A reset in any state (including MEM with mem_req high) SHALL abort the instruction with no pcEn pulse.
REQ-034 After rst returns to 1, the FSM SHALL begin in FETCH with fetch_req=1 (if halt=0) in the first cycle.

Structure
REQ-035 The opcode/ext constants, the cond codes, the state encodings and IMMWIDTH=8 SHALL live in the shared defines.v.
REQ-036 Condition evaluation SHALL be one sub-module, cond_eval (cond, flags -> take), reused by the Jcond and Bcond paths.
REQ-037 pc_seq SHALL drive the existing pc block's branch, jump, pcEn and disp inputs directly.

Verification
REQ-038 ALU: instr=16'h0000 with instr_valid=1 in FETCH -> DECODE, then EXEC with pcEn=1, branch=0, jump=0, then FETCH.
REQ-039 Bcond EQ taken: instr=16'hC07F, flags Z=1 -> in EXEC, pcEn=1, branch=1, disp=8'h7F.
REQ-040 Bcond EQ not taken: the same instruction with Z=0 -> in EXEC, pcEn=1, branch=0.
REQ-041 JAL and Jcond: JAL instr=16'h4081 -> EXEC with pcEn=1, jump=1, link_we=1; Jcond instr=16'h4FC1 (never) -> jump=0.
REQ-042 STOR with wait: instr=16'h4142, mem_ready low for 3 cycles -> MEM held 4 cycles with mem_req=1 and mem_we=1, then pcEn=1 on the mem_ready cycle.
REQ-043 Halt and reset:
- halt=1 in FETCH with instr_valid=1 -> fetch_req=0 and ir unchanged.
- rst=0 during MEM -> next state FETCH, ir=0, no pcEn.
